// File: rtl/dsp_axis_pkg.sv
// Shared constants for the AXI-Stream operand splitter: default sizes and lane indices.
package dsp_axis_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH      = 4;
    localparam int unsigned PKT_COUNT_WIDTH    = 16;

    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned LANE_A    = 0;
    localparam int unsigned LANE_B    = 1;
    localparam int unsigned LANE_C    = 2;

    // Occupancy counter width for a buffer of the given depth (counts 0..depth inclusive).
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dsp_axis_operand_splitter_if.sv
// Bundle of the packed-operand input stream and the three per-lane output streams.
interface dsp_axis_operand_splitter_if #(
    parameter int unsigned DATA_WIDTH = dsp_axis_pkg::DEFAULT_DATA_WIDTH
);

    logic [3*DATA_WIDTH-1:0] s_axis_data;
    logic                    s_axis_valid;
    logic                    s_axis_last;
    logic                    s_axis_ready;

    logic [DATA_WIDTH-1:0]   m_axis_data_a;
    logic [DATA_WIDTH-1:0]   m_axis_data_b;
    logic [DATA_WIDTH-1:0]   m_axis_data_c;
    logic                    m_axis_valid_a;
    logic                    m_axis_valid_b;
    logic                    m_axis_valid_c;
    logic                    m_axis_last_a;
    logic                    m_axis_last_b;
    logic                    m_axis_last_c;
    logic                    m_axis_ready_a;
    logic                    m_axis_ready_b;
    logic                    m_axis_ready_c;

    // Splitter side: consumes the packed stream, sources the lane streams.
    modport slave (
        input  s_axis_data, s_axis_valid, s_axis_last,
        output s_axis_ready,
        output m_axis_data_a, m_axis_data_b, m_axis_data_c,
        output m_axis_valid_a, m_axis_valid_b, m_axis_valid_c,
        output m_axis_last_a, m_axis_last_b, m_axis_last_c,
        input  m_axis_ready_a, m_axis_ready_b, m_axis_ready_c
    );

    // Environment side: sources the packed stream, consumes the lane streams.
    modport master (
        output s_axis_data, s_axis_valid, s_axis_last,
        input  s_axis_ready,
        input  m_axis_data_a, m_axis_data_b, m_axis_data_c,
        input  m_axis_valid_a, m_axis_valid_b, m_axis_valid_c,
        input  m_axis_last_a, m_axis_last_b, m_axis_last_c,
        output m_axis_ready_a, m_axis_ready_b, m_axis_ready_c
    );

endinterface

// File: rtl/dsp_axis_operand_splitter_lane_fifo.sv
// Per-lane buffer holding operand data plus its last flag, with occupancy and
// a look-ahead full flag so the upstream ready can be registered.
module axis_lane_fifo
    import dsp_axis_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        push_last,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        pop_last,
    output logic                        full,
    output logic                        full_nxt,
    output logic                        empty,
    output logic [occ_width(DEPTH)-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [WIDTH:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_nxt;
    logic               do_push;
    logic               do_pop;

    // Guard both ends so a stray request can never corrupt the pointers.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_nxt = occ;
        unique case ({do_push, do_pop})
            2'b10:   occ_nxt = occ + OCC_W'(1);
            2'b01:   occ_nxt = occ - OCC_W'(1);
            default: occ_nxt = occ;
        endcase
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ_nxt;
        end
    end

    // Entry storage; contents are only observed through the occupancy-qualified head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_last, push_data};
        end
    end

    assign empty     = (occ == '0);
    assign full      = (occ == OCC_W'(DEPTH));
    assign full_nxt  = (occ_nxt == OCC_W'(DEPTH));
    assign occupancy = occ;

    // Head entry is forced to zero while empty so reset and idle outputs are clean.
    assign pop_data = empty ? '0   : mem[rd_ptr][WIDTH-1:0];
    assign pop_last = empty ? 1'b0 : mem[rd_ptr][WIDTH];

endmodule

// File: rtl/dsp_axis_operand_splitter.sv
// Splits a packed {c, b, a} operand stream into three independently drained
// lane streams, each buffered so slow consumers do not stall the others
// until their buffer fills.
module dsp_axis_operand_splitter
    import dsp_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    dsp_axis_operand_splitter_if.slave axis,
    output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic                  in_ready;
    logic                  accept;
    logic [NUM_LANES-1:0]  lane_ready;
    logic [NUM_LANES-1:0]  lane_valid;
    logic [NUM_LANES-1:0]  lane_pop;
    logic [NUM_LANES-1:0]  lane_last;
    logic [NUM_LANES-1:0]  lane_full;
    logic [NUM_LANES-1:0]  lane_full_nxt;
    logic [NUM_LANES-1:0]  lane_empty;
    logic [DATA_WIDTH-1:0] lane_data [NUM_LANES];
    logic [OCC_W-1:0]      lane_occ  [NUM_LANES];

    // A beat is taken only when every lane has room.
    assign accept = axis.s_axis_valid & in_ready & ~(|lane_full);

    // Gather the per-lane downstream readies into a vector.
    always_comb begin
        lane_ready         = '0;
        lane_ready[LANE_A] = axis.m_axis_ready_a;
        lane_ready[LANE_B] = axis.m_axis_ready_b;
        lane_ready[LANE_C] = axis.m_axis_ready_c;
    end

    // One buffer per lane; all three are written by the same accepted beat.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        axis_lane_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (reset),
            .push      (accept),
            .push_data (axis.s_axis_data[l*DATA_WIDTH +: DATA_WIDTH]),
            .push_last (axis.s_axis_last),
            .pop       (lane_pop[l]),
            .pop_data  (lane_data[l]),
            .pop_last  (lane_last[l]),
            .full      (lane_full[l]),
            .full_nxt  (lane_full_nxt[l]),
            .empty     (lane_empty[l]),
            .occupancy (lane_occ[l])
        );

        assign lane_valid[l] = (lane_occ[l] != '0);
        assign lane_pop[l]   = ~lane_empty[l] & lane_ready[l];
    end

    // Upstream ready registered from next-cycle occupancy, so it never sees m_axis_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= ~(|lane_full_nxt);
        end
    end

    // Packets accepted: one per beat carrying last, wrapping at the counter width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
        end else if (accept && axis.s_axis_last) begin
            pkt_count <= pkt_count + PKT_COUNT_WIDTH'(1);
        end
    end

    assign axis.s_axis_ready   = in_ready;

    assign axis.m_axis_data_a  = lane_data[LANE_A];
    assign axis.m_axis_data_b  = lane_data[LANE_B];
    assign axis.m_axis_data_c  = lane_data[LANE_C];
    assign axis.m_axis_valid_a = lane_valid[LANE_A];
    assign axis.m_axis_valid_b = lane_valid[LANE_B];
    assign axis.m_axis_valid_c = lane_valid[LANE_C];
    assign axis.m_axis_last_a  = lane_last[LANE_A];
    assign axis.m_axis_last_b  = lane_last[LANE_B];
    assign axis.m_axis_last_c  = lane_last[LANE_C];

endmodule

// File: tb/tb_dsp_axis_operand_splitter.sv
// Bench for the operand splitter: a queue-per-lane reference model checked
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_dsp_axis_operand_splitter;
    import dsp_axis_pkg::*;

    localparam int DW      = 16;
    localparam int DEPTH_I = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pkt_count;
    int          errors = 0;
    int          checks = 0;

    // Reference state: per-lane FIFOs of {last, data}, packet count, out-of-reset flag.
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] qc[$];
    int          m_pkt;
    bit          m_run;
    bit          sends_done;

    always #5 clk = ~clk;

    dsp_axis_operand_splitter_if #(.DATA_WIDTH(DW)) bus ();

    dsp_axis_operand_splitter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH_I)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .axis      (bus),
        .pkt_count (pkt_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return m_run && qa.size() < DEPTH_I && qb.size() < DEPTH_I && qc.size() < DEPTH_I;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        qc.delete();
        m_pkt = 0;
        m_run = 1'b0;
    endtask

    // One clock of the reference: pops decided on pre-edge contents, then the push.
    task automatic model_step();
        bit acc, pa, pb, pc;
        acc = model_ready() && bus.s_axis_valid;
        pa  = qa.size() != 0 && bus.m_axis_ready_a;
        pb  = qb.size() != 0 && bus.m_axis_ready_b;
        pc  = qc.size() != 0 && bus.m_axis_ready_c;
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (pc) void'(qc.pop_front());
        if (acc) begin
            qa.push_back({bus.s_axis_last, bus.s_axis_data[15:0]});
            qb.push_back({bus.s_axis_last, bus.s_axis_data[31:16]});
            qc.push_back({bus.s_axis_last, bus.s_axis_data[47:32]});
            if (bus.s_axis_last) m_pkt = (m_pkt + 1) % 65536;
        end
        m_run = 1'b1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    task automatic check_lane(input string name, input logic v, input logic l,
                              input logic [15:0] d, input int n, input logic [16:0] head);
        chk({name, "_valid"}, 32'(v), 32'(n != 0));
        if (!rst) begin
            chk({name, "_data_rst"}, 32'(d), 32'd0);
            chk({name, "_last_rst"}, 32'(l), 32'd0);
        end else if (n != 0) begin
            chk({name, "_data"}, 32'(d), 32'(head[15:0]));
            chk({name, "_last"}, 32'(l), 32'(head[16]));
        end
    endtask

    // Compare process: DUT against the reference on every falling edge.
    always @(negedge clk) begin
        chk("s_axis_ready", 32'(bus.s_axis_ready), 32'(model_ready()));
        chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
        check_lane("lane_a", bus.m_axis_valid_a, bus.m_axis_last_a, bus.m_axis_data_a,
                   qa.size(), (qa.size() != 0) ? qa[0] : 17'd0);
        check_lane("lane_b", bus.m_axis_valid_b, bus.m_axis_last_b, bus.m_axis_data_b,
                   qb.size(), (qb.size() != 0) ? qb[0] : 17'd0);
        check_lane("lane_c", bus.m_axis_valid_c, bus.m_axis_last_c, bus.m_axis_data_c,
                   qc.size(), (qc.size() != 0) ? qc[0] : 17'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic ra, input logic rb, input logic rc);
        bus.m_axis_ready_a = ra;
        bus.m_axis_ready_b = rb;
        bus.m_axis_ready_c = rc;
    endtask

    // Present one beat and hold it until taken; returns just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic last);
        bit accepted;
        accepted         = 1'b0;
        bus.s_axis_data  = {c, b, a};
        bus.s_axis_last  = last;
        bus.s_axis_valid = 1'b1;
        for (int i = 0; i < 60 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.s_axis_ready;
            @(posedge clk);
            #1;
        end
        bus.s_axis_valid = 1'b0;
        bus.s_axis_last  = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 60 cycles");
        end
    endtask

    initial begin
        rst              = 1'b0;
        bus.s_axis_data  = '0;
        bus.s_axis_valid = 1'b0;
        bus.s_axis_last  = 1'b0;
        sends_done       = 1'b0;
        set_ready(1'b1, 1'b1, 1'b1);
        repeat (3) tick();

        // Reset state
        chk("rst_ready", 32'(bus.s_axis_ready), 32'd0);
        chk("rst_valid_a", 32'(bus.m_axis_valid_a), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        rst = 1'b1;
        tick();
        chk("ready_after_reset", 32'(bus.s_axis_ready), 32'd1);

        // Single beat {3,2,1} with last
        send(16'd1, 16'd2, 16'd3, 1'b1);
        chk("single_a", 32'(bus.m_axis_data_a), 32'd1);
        chk("single_b", 32'(bus.m_axis_data_b), 32'd2);
        chk("single_c", 32'(bus.m_axis_data_c), 32'd3);
        chk("single_valid_b", 32'(bus.m_axis_valid_b), 32'd1);
        chk("single_last_c", 32'(bus.m_axis_last_c), 32'd1);
        chk("single_pkt", 32'(pkt_count), 32'd1);
        repeat (3) tick();

        // Zero operands are still valid data
        send(16'd0, 16'd0, 16'd0, 1'b0);
        chk("zero_valid_a", 32'(bus.m_axis_valid_a), 32'd1);
        chk("zero_valid_b", 32'(bus.m_axis_valid_b), 32'd1);
        chk("zero_valid_c", 32'(bus.m_axis_valid_c), 32'd1);
        chk("zero_data_b", 32'(bus.m_axis_data_b), 32'd0);
        repeat (3) tick();

        // Backpressure on lane b fills its buffer after four beats
        set_ready(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(16'(10 + i), 16'(20 + i), 16'(30 + i), i == 3);
        chk("bp_ready_low", 32'(bus.s_axis_ready), 32'd0);
        repeat (3) tick();
        chk("bp_a_drained", 32'(bus.m_axis_valid_a), 32'd0);
        chk("bp_b_valid", 32'(bus.m_axis_valid_b), 32'd1);
        chk("bp_b_head", 32'(bus.m_axis_data_b), 32'd20);
        chk("bp_pkt", 32'(pkt_count), 32'd2);

        // Release lane b: ready returns right after its first pop
        set_ready(1'b1, 1'b1, 1'b1);
        tick();
        chk("release_ready", 32'(bus.s_axis_ready), 32'd1);
        chk("release_b_next", 32'(bus.m_axis_data_b), 32'd21);
        repeat (4) tick();
        chk("release_b_empty", 32'(bus.m_axis_valid_b), 32'd0);

        // Wrap: ten beats 0..9 under random per-lane ready
        fork
            begin
                for (int i = 0; i < 10; i++) send(16'(i), 16'(i), 16'(i), i == 9);
                sends_done = 1'b1;
            end
            begin
                for (int n = 0; n < 400 && !sends_done; n++) begin
                    set_ready(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
                    tick();
                end
            end
        join
        set_ready(1'b1, 1'b1, 1'b1);
        repeat (12) tick();
        chk("wrap_a_empty", 32'(bus.m_axis_valid_a), 32'd0);
        chk("wrap_c_empty", 32'(bus.m_axis_valid_c), 32'd0);
        chk("wrap_pkt", 32'(pkt_count), 32'd3);

        // Reset with two beats buffered mid-packet
        set_ready(1'b0, 1'b0, 1'b0);
        send(16'd1, 16'd1, 16'd1, 1'b0);
        send(16'd2, 16'd2, 16'd2, 1'b0);
        chk("mid_buffered", 32'(bus.m_axis_valid_a), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_valid_a", 32'(bus.m_axis_valid_a), 32'd0);
        chk("mid_valid_b", 32'(bus.m_axis_valid_b), 32'd0);
        chk("mid_valid_c", 32'(bus.m_axis_valid_c), 32'd0);
        chk("mid_pkt", 32'(pkt_count), 32'd0);
        chk("mid_ready", 32'(bus.s_axis_ready), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_ready", 32'(bus.s_axis_ready), 32'd1);
        set_ready(1'b1, 1'b1, 1'b1);
        send(16'd5, 16'd6, 16'd7, 1'b1);
        chk("post_a", 32'(bus.m_axis_data_a), 32'd5);
        chk("post_b", 32'(bus.m_axis_data_b), 32'd6);
        chk("post_c", 32'(bus.m_axis_data_c), 32'd7);
        chk("post_pkt", 32'(pkt_count), 32'd1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_axis_operand_splitter.md
DSP_AXIS_OPERAND_SPLITTER -- requirements
Module: dsp_axis_operand_splitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of one operand lane.
REQ-002 SHALL have parameter DEPTH, default 4, the entries per lane buffer; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_data, input, 3*DATA_WIDTH: packed operands, {c, b, a}, with a in the LSBs.
REQ-006 SHALL have port s_axis_valid, input, 1 bit: the input beat is valid.
REQ-007 SHALL have port s_axis_last, input, 1 bit: the input beat ends a packet.
REQ-008 SHALL have port s_axis_ready, output, 1 bit: the block accepts an input beat.
REQ-009 SHALL have, for each lane x in {a, b, c}, port m_axis_data_x, output, DATA_WIDTH: operand x.
REQ-010 SHALL have, for each lane x, port m_axis_valid_x, output, 1 bit.
REQ-011 SHALL have, for each lane x, port m_axis_last_x, output, 1 bit.
REQ-012 SHALL have, for each lane x, port m_axis_ready_x, input, 1 bit: the lane's downstream consumer accepts.
REQ-013 SHALL have port pkt_count, output, 16 bits: count of packets accepted on the input.

Function
REQ-014 SHALL accept an input beat only in a cycle where s_axis_valid and s_axis_ready are both 1.
REQ-015 SHALL drive s_axis_ready to 1 only when none of the three lane buffers is full; it is derived from buffer occupancy only, with no combinational path from any m_axis_ready_x.
REQ-016 SHALL, on acceptance, write the a, b and c slices together with s_axis_last into their lane buffers in the same cycle.
REQ-017 SHALL operate each lane independently: the lane pops one entry when m_axis_valid_x and m_axis_ready_x are both 1; lanes drain at different rates.
REQ-018 SHALL drive m_axis_valid_x to 1 exactly when lane x occupancy is nonzero, independent of the data value; zero operands are valid data.
REQ-019 SHALL present accepted data on the lane outputs one cycle after acceptance when the lane was empty; there is no same-cycle pass-through.
REQ-020 SHALL hold m_axis_data_x and m_axis_last_x stable while m_axis_valid_x is 1 and m_axis_ready_x is 0.
REQ-021 SHALL drive m_axis_last_x as the stored s_axis_last of the entry at the head of lane x.
REQ-022 SHALL keep occupancy unchanged on a simultaneous push and pop in a lane; both pointers advance.
REQ-023 SHALL let read and write pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
REQ-024 SHALL never overflow a lane: a push into a full lane is impossible because s_axis_ready is 0.
REQ-025 SHALL never underflow a lane: a pop from an empty lane is impossible because m_axis_valid_x is 0.
REQ-026 SHALL increment pkt_count by 1 on each accepted beat with s_axis_last=1, wrapping from 0xFFFF to 0x0000.

Reset
REQ-027 SHALL, while reset=0, force all pointers, occupancies and pkt_count to 0, and drive m_axis_valid_x=0, m_axis_last_x=0, m_axis_data_x=0 and s_axis_ready=0.
REQ-028 SHALL discard all buffered entries on reset asserted mid-packet; no partial packet survives.
REQ-029 SHALL drive s_axis_ready to 1 in the first clock after reset deassertion.

Structure
REQ-030 SHALL take DATA_WIDTH and DEPTH defaults and the lane index constants (LANE_A=0, LANE_B=1, LANE_C=2) from the shared package dsp_axis_pkg.
REQ-031 SHALL instantiate the sub-module axis_lane_fifo (data plus last, DEPTH entries, with full, empty and occupancy) three times, one per lane.

Verification
REQ-032 SHALL verify the single beat: s_axis_data={16'd3,16'd2,16'd1}, last=1, all m_axis_ready_x=1 -> one cycle later the lanes show a=1, b=2, c=3 with valid=1 and last=1; pkt_count=1.
REQ-033 SHALL verify a zero operand: input {0,0,0} -> all m_axis_valid_x=1 with data 0.
REQ-034 SHALL verify backpressure: m_axis_ready_b=0, four beats pushed -> s_axis_ready=0 after the 4th beat; lane a drains; lane b holds its first beat stable.
REQ-035 SHALL verify independent drain: release lane b -> it drains 4 beats in order; s_axis_ready returns to 1 the cycle after the first lane b pop.
REQ-036 SHALL verify wrap: 10 beats with values 0..9, random per-lane ready -> every lane outputs 0..9 in order, with no loss or duplication.
REQ-037 SHALL verify mid-packet reset: reset=0 with 2 beats buffered -> all valids=0 and pkt_count=0; after release, a new beat flows normally.
